// File: rtl/cbrt_feeder.sv
// Operand FIFO and issue/capture sequencer for the iterative cube-root core.
// One operation in flight; results leave through a registered output slot.
module cbrt_feeder #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_data,
  output logic [7:0]               out_x,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     cb_start,
  output logic [7:0]               cb_x,
  input  logic                     cb_busy,
  input  logic [2:0]               cb_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WD_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WD_ONE  = WW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [WW-1:0] wd;
  logic [WW-1:0] wd_nx;
  logic          first;
  logic          push;
  logic          pop;
  logic          capture;
  logic          expire;

  assign in_ready   = rst && (count < LVL_MAX);
  assign push       = in_valid && in_ready;
  assign fifo_level = count;
  assign cb_start   = (state == ISSUE);
  assign wd_nx      = (wd == WD_MAX) ? wd : wd + WD_ONE;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && !cb_busy) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (cb_busy) begin
          if (wd_nx == WD_MAX) begin
            expire   = 1'b1;
            state_nx = IDLE;
          end
        end else if (!first &&
                     (!out_valid || out_ready)) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      first       <= 1'b0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      first       <= (state == ISSUE);
      timeout_err <= timeout_err | expire;
      if (state == ISSUE)
        wd <= '0;
      else if (state == WAIT && cb_busy)
        wd <= wd_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      cb_x   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cb_x   <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A capture in the same cycle as an accept refills the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= cb_result;
      out_x     <= cb_x;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cbrt_feeder.sv
// Bench for cbrt_feeder with a behavioural multi-cycle cube-root core.
// Vector table, scoreboard and corner-case sequences.
module tb_cbrt_feeder;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 16;
  localparam int LAT      = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_data;
  logic [7:0] out_x;
  logic       timeout_err;
  logic [2:0] fifo_level;
  logic       cb_start;
  logic [7:0] cb_x;
  logic       cb_busy;
  logic [2:0] cb_result;
  logic       force_busy = 1'b0;

  always #5 clk = ~clk;

  cbrt_feeder #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x),
    .timeout_err(timeout_err), .fifo_level(fifo_level),
    .cb_start(cb_start), .cb_x(cb_x),
    .cb_busy(cb_busy), .cb_result(cb_result)
  );

  function automatic logic [2:0] cbrt_ref(input logic [7:0] x);
    int r = 0;
    while ((r+1)*(r+1)*(r+1) <= int'(x)) r++;
    return 3'(r);
  endfunction

  logic       m_busy;
  logic [3:0] m_cnt;
  logic [7:0] m_x;
  logic [2:0] m_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_x    <= '0;
      m_res  <= '0;
    end else if (cb_start && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'(LAT);
      m_x    <= cb_x;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_busy <= 1'b0;
        m_res  <= cbrt_ref(m_x);
      end
    end
  end

  assign cb_busy   = m_busy | force_busy;
  assign cb_result = m_res;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int n_start = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [2:0] y;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (in_valid && in_ready)
        sbq.push_back('{in_data, cbrt_ref(in_data)});
      if (cb_start)
        n_start++;
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_x", 32'(out_x), 32'(e.x));
          chk("sb_y", 32'(out_data), 32'(e.y));
        end
      end
    end
  end

  task automatic push1(input logic [7:0] x);
    int k;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = x;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_start(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cb_start) break;
    end
    chk(nm, 32'(cb_start), 32'd1);
  endtask

  task automatic wait_nout(input int target, input string nm);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (n_out >= target) break;
    end
    chk(nm, 32'(n_out), 32'(target));
  endtask

  typedef struct {
    logic [7:0] x;
    logic [2:0] y;
  } vec_t;

  vec_t vt[8];
  logic [7:0] burst[6];

  initial begin
    int s0;
    int so;
    int i;
    int guard;
    int cnt;
    bit saw;

    vt[0] = '{8'd27, 3'd3};
    vt[1] = '{8'd0, 3'd0};
    vt[2] = '{8'd9, 3'd2};
    vt[3] = '{8'd1, 3'd1};
    vt[4] = '{8'd7, 3'd1};
    vt[5] = '{8'd8, 3'd2};
    vt[6] = '{8'd63, 3'd3};
    vt[7] = '{8'd64, 3'd4};
    burst = '{8'd1, 8'd8, 8'd64, 8'd125, 8'd216, 8'd255};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_cb_start", 32'(cb_start), 32'd0);
    chk("rst_cb_x", 32'(cb_x), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      s0 = n_start;
      push1(vt[v].x);
      wait_out("tbl_valid");
      chk("tbl_data", 32'(out_data), 32'(vt[v].y));
      chk("tbl_x", 32'(out_x), 32'(vt[v].x));
      chk("tbl_cb_x", 32'(cb_x), 32'(vt[v].x));
      @(negedge clk);
      chk("tbl_pulse", 32'(out_valid), 32'd0);
      chk("tbl_level", 32'(fifo_level), 32'd0);
      chk("tbl_starts", 32'(n_start - s0), 32'd1);
    end

    so = n_out;
    saw = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = burst[0];
    i = 0;
    guard = 0;
    while (i < 6 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (fifo_level == 3'd4) begin
        saw = 1'b1;
        chk("full_ready", 32'(in_ready), 32'd0);
      end
      if (in_ready) begin
        @(posedge clk);
        #1 i++;
        if (i < 6) in_data = burst[i];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("burst_pushed", 32'(i), 32'd6);
    chk("burst_full_seen", 32'(saw), 32'd1);
    wait_nout(so + 6, "burst_outputs");
    chk("burst_sb_empty", 32'(sbq.size()), 32'd0);

    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    s0 = n_start;
    push1(8'd26);
    push1(8'd28);
    wait_out("bp_valid");
    repeat (30) @(negedge clk);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_x", 32'(out_x), 32'd26);
    chk("bp_hold_data", 32'(out_data), 32'd2);
    chk("bp_second_issued", 32'(n_start - s0), 32'd2);
    chk("bp_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_x", 32'(out_x), 32'd28);
    chk("bp_next_data", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    so = n_out;
    @(posedge clk);
    #1 force_busy = 1'b1;
    push1(8'd0);
    push1(8'd9);
    @(negedge clk);
    chk("pp_level_pre", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #1 force_busy = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd27;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pp_level_same", 32'(fifo_level), 32'd2);
    wait_nout(so + 3, "pp_outputs");

    repeat (3) @(negedge clk);
    push1(8'd100);
    wait_start("stuck_start");
    @(posedge clk);
    #1 force_busy = 1'b1;
    cnt = 1;
    saw = 1'b0;
    @(negedge clk);
    while (!timeout_err && cnt < 100) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk("to_flag", 32'(timeout_err), 32'd1);
    chk("to_cycles", 32'(cnt), 32'd17);
    chk("to_no_output", 32'(saw), 32'd0);
    if (sbq.size() > 0) void'(sbq.pop_front());
    repeat (5) @(negedge clk);
    chk("to_no_output_after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 force_busy = 1'b0;
    so = n_out;
    push1(8'd8);
    wait_out("to_next_valid");
    chk("to_next_x", 32'(out_x), 32'd8);
    chk("to_next_data", 32'(out_data), 32'd2);
    wait_nout(so + 1, "to_next_out");
    chk("to_sticky", 32'(timeout_err), 32'd1);

    repeat (3) @(negedge clk);
    push1(8'd200);
    wait_start("mid_start");
    push1(8'd1);
    push1(8'd2);
    push1(8'd3);
    @(negedge clk);
    chk("mid_level", 32'(fifo_level), 32'd3);
    chk("mid_busy", 32'(cb_busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_start", 32'(cb_start), 32'd0);
    chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    so = n_out;
    push1(8'd125);
    wait_out("after_rst_valid");
    chk("after_rst_x", 32'(out_x), 32'd125);
    chk("after_rst_data", 32'(out_data), 32'd5);
    wait_nout(so + 1, "after_rst_out");
    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cbrt_feeder.md
Name: cbrt_feeder

Overview:
- Upstream/downstream sequencer for the iterative cube-root unit (cbrt, 8-bit in, 3-bit out, start/busy protocol).
- Accepts a stream of 8-bit operands on a valid/ready interface and buffers them in a small FIFO.
- Issues one operand at a time to cbrt and collects each result into a registered valid/ready output stream, paired with its operand.
- Watchdog flags a hung cbrt.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- MAX_WAIT, 2000, max cycles cb_busy may stay high per operation before timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  operand valid.
- in_ready  out  1  FIFO can accept an operand.
- in_data  in  8  operand x.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  3  floor(cbrt(x)).
- out_x  out  8  operand that produced out_data.
- timeout_err  out  1  sticky watchdog flag.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- cb_start  out  1  start pulse to cbrt.
- cb_x  out  8  operand to cbrt; held stable from issue until capture.
- cb_busy  in  1  cbrt busy.
- cb_result  in  3  cbrt result; valid while cb_busy=0 after an operation.

Behaviour:
- Reset (rst=0, async): FIFO empty, fifo_level=0, FSM=IDLE.
  - in_ready=0 while in reset, 1 after reset releases.
  - out_valid=0, out_data=0, out_x=0, cb_start=0, cb_x=0, timeout_err=0, watchdog=0.
- FIFO:
  - Push on in_valid&&in_ready.
  - in_ready = (fifo_level<DEPTH), registered-count based; it does not look ahead to a same-cycle pop.
  - Pop only by the FSM in IDLE.
  - Simultaneous push and pop: level unchanged, order preserved.
  - Read/write pointers wrap modulo DEPTH; occupancy is held as an explicit count.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty and cb_busy=0, pop the head into cb_x and go to ISSUE.
    - Issue is allowed while out_valid=1; backpressure is applied at capture, not at issue.
  - ISSUE: cb_start=1 for exactly this one cycle. Clear the watchdog, then go to WAIT.
  - WAIT: cb_busy is ignored in the first WAIT cycle (cbrt raises busy on the edge that samples start). From the second WAIT cycle onward:
    - Capture: if cb_busy=0 and (out_valid=0 or out_ready=1), load out_data<=cb_result, out_x<=cb_x, out_valid<=1, then go to IDLE.
    - Stall: if cb_busy=0 but the output slot is full and not being accepted, remain in WAIT. The cbrt result is stable while idle.
    - Watchdog: increments on each cycle with cb_busy=1. On reaching MAX_WAIT, set timeout_err=1 (sticky until reset), discard the operation (no output), and go to IDLE.
- Output register:
  - out_valid clears on out_valid&&out_ready unless a new capture happens in the same cycle.
  - out_data and out_x hold while out_valid=1 && out_ready=0.
- Latency: push of an operand into an empty FIFO with an idle core:
  - edge 1: push;
  - edge 2: pop to ISSUE;
  - edge 3: cb_start sampled;
  - then cbrt compute time;
  - then 1 cycle after cb_busy falls, out_valid rises.
- Throughput: one operation in flight; ordering is strictly FIFO.
- Reset mid-operation:
  - Buffered operands and any pending result are lost.
  - The first operand pushed after reset is issued only once cb_busy=0; cbrt is assumed reset by system logic.
- Arithmetic: none beyond pointer and counter increments.
  - Watchdog width is clog2(MAX_WAIT+1) and it saturates at MAX_WAIT.

Test Plan:
- Single operand 27, out_ready=1 -> exactly one cb_start pulse, cb_x=27; out_valid pulses once with out_data=3, out_x=27; fifo_level returns to 0.
- Burst 1,8,64,125,216,255 pushed back-to-back with DEPTH=4 and the real cbrt -> in_ready deasserts when level=4; outputs arrive in order as (1,1),(8,2),(64,4),(125,5),(216,6),(255,6); no operand lost or duplicated.
- Backpressure: hold out_ready=0, push 26 then 28 -> first result (26,2) holds stable; the second operation issues and stalls in WAIT; on releasing out_ready, (28,3) follows on the next accept.
- Boundaries 0 and 9 -> (0,0) and (9,2); a simultaneous push/pop at level 2 keeps level 2.
- Stuck model with cb_busy held at 1 and MAX_WAIT=16 -> timeout_err rises after 16 busy cycles, no out_valid, FSM back to IDLE. Once busy is released, the next operand 8 completes as (8,2) and timeout_err stays 1.
- Assert rst=0 mid-WAIT with 3 operands queued -> immediately out_valid=0, fifo_level=0, cb_start=0, timeout_err=0. After release, a push of 125 yields (125,5).
